// File: rtl/raptor64_div_arb.sv
// rtl/raptor64_div_arb.sv - two-port round-robin arbiter and sequencer for the shared 64-bit iterative divider
module raptor64_div_arb #(
  parameter int WID = 64,
  parameter int TMO = 100,
  parameter int TW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  // port 0: integer pipeline
  input  logic           req0,
  output logic           ack0,
  input  logic           sgn0,
  input  logic           isDivi0,
  input  logic [WID-1:0] a0,
  input  logic [WID-1:0] b0,
  input  logic [WID-1:0] imm0,
  // port 1: secondary / microcode issue
  input  logic           req1,
  output logic           ack1,
  input  logic           sgn1,
  input  logic           isDivi1,
  input  logic [WID-1:0] a1,
  input  logic [WID-1:0] b1,
  input  logic [WID-1:0] imm1,
  // shared response bus
  output logic           rsp_v,
  output logic           rsp_id,
  output logic [WID-1:0] rsp_q,
  output logic [WID-1:0] rsp_r,
  output logic           rsp_dz,
  output logic           rsp_to,
  input  logic           rsp_rdy,
  // divider interface
  output logic           div_rst,
  output logic           div_ld,
  output logic           div_sgn,
  output logic           div_isDivi,
  output logic [WID-1:0] div_a,
  output logic [WID-1:0] div_b,
  output logic [WID-1:0] div_imm,
  input  logic [WID-1:0] div_qo,
  input  logic [WID-1:0] div_ro,
  input  logic           div_dz,
  input  logic           div_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Last watchdog count before giving up on div_done, and the saturation ceiling.
  localparam logic [TW-1:0] CNT_LAST = TW'(TMO - 1);
  localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};

  state_t        state;
  state_t        state_nxt;
  logic          rst_hold;   // keeps div_rst high for the first clock after reset release
  logic          ptr;        // port favoured when both request together
  logic          gid;        // owner of the operation in flight
  logic [TW-1:0] cnt;        // watchdog, cycles spent in WAIT
  logic          grant0;
  logic          grant1;
  logic          take_done;
  logic          take_to;

  // Stretch reset by one clock so the divider always sees a synchronous reset edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_hold <= 1'b1;
    else        rst_hold <= 1'b0;
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus all strobes: grants, load, watchdog reset, response valid.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    take_done = 1'b0;
    take_to   = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    div_ld    = 1'b0;
    div_rst   = rst_hold;
    rsp_v     = 1'b0;
    case (state)
      IDLE: begin
        // No grant while the divider is still coming out of reset.
        if (!rst_hold) begin
          if (req0 && (!req1 || !ptr)) grant0 = 1'b1;
          else if (req1)               grant1 = 1'b1;
          ack0 = grant0;
          ack1 = grant1;
          if (grant0 || grant1) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // A stale done from a previous op is ignored here by construction.
        div_ld    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          take_done = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          take_to   = 1'b1;
          div_rst   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_v = 1'b1;
        if (rsp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted port's operands; they feed the divider until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= 1'b0;
      gid        <= 1'b0;
      div_sgn    <= 1'b0;
      div_isDivi <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      div_imm    <= '0;
    end else if (grant0) begin
      ptr        <= 1'b1;
      gid        <= 1'b0;
      div_sgn    <= sgn0;
      div_isDivi <= isDivi0;
      div_a      <= a0;
      div_b      <= b0;
      div_imm    <= imm0;
    end else if (grant1) begin
      ptr        <= 1'b0;
      gid        <= 1'b1;
      div_sgn    <= sgn1;
      div_isDivi <= isDivi1;
      div_a      <= a1;
      div_b      <= b1;
      div_imm    <= imm1;
    end
  end

  // Watchdog: cleared on load, counts while waiting, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               cnt <= '0;
    else if (state == ISSUE)                  cnt <= '0;
    else if (state == WAIT && cnt != CNT_MAX) cnt <= cnt + TW'(1);
  end

  // Response registers: divider results on done, zeroed with error flag on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q  <= '0;
      rsp_r  <= '0;
      rsp_dz <= 1'b0;
      rsp_to <= 1'b0;
    end else if (take_done) begin
      rsp_q  <= div_qo;
      rsp_r  <= div_ro;
      rsp_dz <= div_dz;
      rsp_to <= 1'b0;
    end else if (take_to) begin
      rsp_q  <= '0;
      rsp_r  <= '0;
      rsp_dz <= 1'b0;
      rsp_to <= 1'b1;
    end
  end

  assign rsp_id = gid;

endmodule

// File: tb/tb_raptor64_div_arb.sv
// tb/tb_raptor64_div_arb.sv - self-checking bench for raptor64_div_arb with a stub divider
module tb_raptor64_div_arb;

  localparam int WID = 64;
  localparam int TMO = 100;

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, sgn0 = 1'b0, isDivi0 = 1'b0;
  logic [63:0] a0 = '0, b0 = '0, imm0 = '0;
  logic        req1 = 1'b0, sgn1 = 1'b0, isDivi1 = 1'b0;
  logic [63:0] a1 = '0, b1 = '0, imm1 = '0;
  logic        ack0, ack1;
  logic        rsp_v, rsp_id, rsp_dz, rsp_to;
  logic [63:0] rsp_q, rsp_r;
  logic        rsp_rdy = 1'b0;
  logic        div_rst, div_ld, div_sgn, div_isDivi;
  logic [63:0] div_a, div_b, div_imm;
  logic [63:0] div_qo = '0, div_ro = '0;
  logic        div_dz = 1'b0, div_done = 1'b0;

  int checks = 0;
  int failures = 0;

  raptor64_div_arb #(.WID(WID), .TMO(TMO), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .ack0(ack0), .sgn0(sgn0), .isDivi0(isDivi0), .a0(a0), .b0(b0), .imm0(imm0),
    .req1(req1), .ack1(ack1), .sgn1(sgn1), .isDivi1(isDivi1), .a1(a1), .b1(b1), .imm1(imm1),
    .rsp_v(rsp_v), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz),
    .rsp_to(rsp_to), .rsp_rdy(rsp_rdy),
    .div_rst(div_rst), .div_ld(div_ld), .div_sgn(div_sgn), .div_isDivi(div_isDivi),
    .div_a(div_a), .div_b(div_b), .div_imm(div_imm),
    .div_qo(div_qo), .div_ro(div_ro), .div_dz(div_dz), .div_done(div_done)
  );

  always #5 clk = ~clk;

  // Reference divide: divisor is imm when isDivi, zero divisor gives all-ones quotient and dividend remainder.
  function automatic res_t model(input bit s, input bit di, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] imm);
    res_t x;
    logic [63:0] d;
    d = di ? imm : b;
    if (d == 64'd0) begin
      x.q = '1; x.r = a; x.dz = 1'b1;
    end else if (s) begin
      x.q = $signed(a) / $signed(d); x.r = $signed(a) % $signed(d); x.dz = 1'b0;
    end else begin
      x.q = a / d; x.r = a % d; x.dz = 1'b0;
    end
    return x;
  endfunction

  // Stub divider: latches operands on div_ld, answers stub_lat clocks later unless stub_never.
  logic        st_s = 1'b0, st_di = 1'b0;
  logic [63:0] st_a = '0, st_b = '0, st_imm = '0;
  int          cd = 0;
  int          stub_lat = 67;
  bit          stub_never = 1'b0;

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (div_rst) begin
      cd <= 0;
    end else if (div_ld) begin
      st_s <= div_sgn; st_di <= div_isDivi; st_a <= div_a; st_b <= div_b; st_imm <= div_imm;
      cd <= stub_never ? 0 : stub_lat;
    end else if (cd == 1) begin
      cd <= 0;
      div_done <= 1'b1;
      {div_qo, div_ro, div_dz} <= model(st_s, st_di, st_a, st_b, st_imm);
    end else if (cd > 1) begin
      cd <= cd - 1;
    end
  end

  task automatic set_port(input int p, input bit s, input bit di, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] imm);
    if (p == 0) begin
      sgn0 = s; isDivi0 = di; a0 = a; b0 = b; imm0 = imm; req0 = 1'b1;
    end else begin
      sgn1 = s; isDivi1 = di; a1 = a; b1 = b; imm1 = imm; req1 = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one grant-to-response cycle and reports what was observed; callers judge it.
  task automatic serve(input bit drop, input int hold, output int port, output bit ld_ok,
                       output int rst_at, output int rst_len, output bit busy_ack, output bit stable,
                       output res_t res, output bit id, output bit to, output bit ok);
    int n;
    port = -1; ld_ok = 0; rst_at = 0; rst_len = 0; busy_ack = 0; stable = 1;
    res = '0; id = 0; to = 0; ok = 0;
    #1;
    for (int i = 0; i < 20 && !(ack0 === 1'b1 || ack1 === 1'b1); i++) @(negedge clk);
    if (!(ack0 === 1'b1 || ack1 === 1'b1)) return;
    port = (ack0 === 1'b1 && ack1 === 1'b1) ? 2 : (ack1 === 1'b1 ? 1 : 0);
    @(negedge clk);
    if (drop) begin
      if (port == 0) req0 = 1'b0;
      if (port == 1) req1 = 1'b0;
    end
    ld_ok = (div_ld === 1'b1 && ack0 === 1'b0 && ack1 === 1'b0);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (div_ld !== 1'b0) ld_ok = 0;
      if (ack0 === 1'b1 || ack1 === 1'b1) busy_ack = 1;
      if (div_rst === 1'b1) begin
        if (rst_at == 0) rst_at = n;
        rst_len++;
      end
      if (rsp_v === 1'b1) break;
    end
    if (rsp_v !== 1'b1) return;
    res.q = rsp_q; res.r = rsp_r; res.dz = rsp_dz; id = rsp_id; to = rsp_to;
    repeat (hold) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) busy_ack = 1;
      if (rsp_v !== 1'b1 || rsp_q !== res.q || rsp_r !== res.r || rsp_dz !== res.dz ||
          rsp_id !== id || rsp_to !== to) stable = 0;
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    ok = (rsp_v === 1'b0);
  endtask

  int   port, rst_at, rst_len;
  bit   ld_ok, busy_ack, stable, id, to, ok;
  res_t res;

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({ack0, ack1, rsp_v, div_ld} !== 4'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {ack0, ack1, rsp_v, div_ld}); end
    checks++; if (div_rst !== 1'b1) begin failures++; $display("FAIL reset_div_rst got=%b exp=1", div_rst); end
    checks++; if ({rsp_q, rsp_r, rsp_dz, rsp_to, rsp_id} !== '0 || {div_a, div_b, div_imm} !== '0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0", rsp_q, div_a); end
    req0 = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (div_rst !== 1'b1) begin failures++; $display("FAIL reset_stretch got=%b exp=1", div_rst); end
    @(negedge clk);
    checks++; if (div_rst !== 1'b0) begin failures++; $display("FAIL reset_release got=%b exp=0", div_rst); end
  endtask

  task automatic test_basic();
    set_port(0, 1, 0, 64'd10005, 64'd27, 64'd0);
    serve(1, 0, port, ld_ok, rst_at, rst_len, busy_ack, stable, res, id, to, ok);
    checks++; if (port != 0 || !ok) begin failures++; $display("FAIL basic_port got=%0d ok=%0d exp=0 ok=1", port, ok); end
    checks++; if (!ld_ok) begin failures++; $display("FAIL basic_div_ld got=bad exp=single pulse after ack"); end
    checks++; if (id !== 1'b0 || res.q !== 64'd370 || res.r !== 64'd15) begin failures++; $display("FAIL basic_result got=id%0d q=%0d r=%0d exp=id0 q=370 r=15", id, res.q, res.r); end
    checks++; if (res.dz !== 1'b0 || to !== 1'b0) begin failures++; $display("FAIL basic_flags got=dz%0d to%0d exp=0 0", res.dz, to); end
  endtask

  task automatic test_both();
    int exp_p;
    do_reset();
    set_port(0, 1, 0, 64'd10005, 64'd27, 64'd0);
    set_port(1, 1, 0, -64'sd10005, 64'd27, 64'd0);
    for (int k = 0; k < 5; k++) begin
      exp_p = k % 2;
      if (k == 4) req1 = 1'b0;
      serve(k == 4, 0, port, ld_ok, rst_at, rst_len, busy_ack, stable, res, id, to, ok);
      checks++; if (port != exp_p || id !== exp_p[0] || !ok) begin failures++; $display("FAIL both_grant%0d got=%0d id=%0d exp=%0d", k, port, id, exp_p); end
      checks++;
      if (res.q !== (exp_p == 0 ? 64'd370 : -64'sd370) || res.r !== (exp_p == 0 ? 64'd15 : -64'sd15)) begin
        failures++; $display("FAIL both_result%0d got=q%0d r%0d exp port %0d values", k, $signed(res.q), $signed(res.r), exp_p);
      end
    end
  endtask

  task automatic test_dz();
    set_port(1, 0, 1, 64'(($urandom << 16) | 32'd1), 64'd9, 64'd0);
    serve(1, 0, port, ld_ok, rst_at, rst_len, busy_ack, stable, res, id, to, ok);
    checks++; if (port != 1 || id !== 1'b1 || res.dz !== 1'b1 || to !== 1'b0 || !ok) begin failures++; $display("FAIL dz got=port%0d id%0d dz%0d to%0d exp=1 1 1 0", port, id, res.dz, to); end
  endtask

  task automatic test_timeout();
    stub_never = 1'b1;
    set_port(0, 0, 0, 64'd100, 64'd7, 64'd0);
    serve(1, 0, port, ld_ok, rst_at, rst_len, busy_ack, stable, res, id, to, ok);
    checks++; if (rst_at != TMO || rst_len != 1) begin failures++; $display("FAIL timeout_div_rst got=at%0d len%0d exp=at%0d len1", rst_at, rst_len, TMO); end
    checks++; if (to !== 1'b1 || res !== '0 || id !== 1'b0 || !ok) begin failures++; $display("FAIL timeout_rsp got=to%0d q%0d r%0d dz%0d exp=1 0 0 0", to, res.q, res.r, res.dz); end
    stub_never = 1'b0;
    set_port(1, 0, 0, 64'd1000, 64'd7, 64'd0);
    serve(1, 0, port, ld_ok, rst_at, rst_len, busy_ack, stable, res, id, to, ok);
    checks++; if (port != 1 || res.q !== 64'd142 || res.r !== 64'd6 || to !== 1'b0 || rst_len != 0) begin failures++; $display("FAIL after_timeout got=q%0d r%0d to%0d exp=142 6 0", res.q, res.r, to); end
  endtask

  task automatic test_hold_rdy();
    res_t e0, e1;
    e0 = model(0, 0, 64'd5000, 64'd3, 64'd0);
    e1 = model(1, 0, 64'd77, 64'd5, 64'd0);
    set_port(0, 0, 0, 64'd5000, 64'd3, 64'd0);
    set_port(1, 1, 0, 64'd77, 64'd5, 64'd0);
    serve(1, 20, port, ld_ok, rst_at, rst_len, busy_ack, stable, res, id, to, ok);
    checks++; if (port != 0 || res !== e0 || !ok) begin failures++; $display("FAIL hold_first got=port%0d q%0d exp=port0 q%0d", port, res.q, e0.q); end
    checks++; if (!stable || busy_ack) begin failures++; $display("FAIL hold_stable got=stable%0d ack%0d exp=1 0", stable, busy_ack); end
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL hold_ack1_after got=%b exp=1", ack1); end
    serve(1, 0, port, ld_ok, rst_at, rst_len, busy_ack, stable, res, id, to, ok);
    checks++; if (port != 1 || id !== 1'b1 || res !== e1) begin failures++; $display("FAIL hold_second got=port%0d q%0d exp=port1 q%0d", port, res.q, e1.q); end
  endtask

  task automatic test_async_reset();
    int bad;
    res_t e;
    set_port(0, 0, 0, 64'd900, 64'd4, 64'd0);
    #1;
    for (int i = 0; i < 20 && ack0 !== 1'b1; i++) @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL areset_ack got=%b exp=1", ack0); end
    @(negedge clk);
    req0 = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rsp_v, ack0, ack1, div_ld, rsp_to} !== 5'b0 || rsp_q !== '0 || div_a !== '0 || div_rst !== 1'b1) begin
      failures++; $display("FAIL areset_outputs got=v%0d ld%0d a%0d rst%0d exp=0 0 0 1", rsp_v, div_ld, div_a, div_rst);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (rsp_v !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL areset_quiet got=%0d bad cycles exp=0", bad); end
    e = model(0, 1, 64'd123456, 64'd0, 64'd1000);
    set_port(0, 0, 1, 64'd123456, 64'd0, 64'd1000);
    serve(1, 0, port, ld_ok, rst_at, rst_len, busy_ack, stable, res, id, to, ok);
    checks++; if (port != 0 || res !== e || !ok) begin failures++; $display("FAIL areset_fresh got=q%0d r%0d exp=q%0d r%0d", res.q, res.r, e.q, e.r); end
  endtask

  task automatic test_random();
    int p, hold;
    bit s, di;
    logic [63:0] a, b, imm, d;
    res_t e;
    for (int k = 0; k < 10; k++) begin
      p = $urandom_range(0, 1);
      s = 1'($urandom_range(0, 1));
      di = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 100000));
      imm = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'($urandom_range(0, 3)), $urandom};
      d = di ? imm : b;
      if (s && d == '1) begin
        if (di) imm = 64'd3; else b = 64'd3;
      end
      e = model(s, di, a, b, imm);
      hold = $urandom_range(0, 3);
      set_port(p, s, di, a, b, imm);
      serve(1, hold, port, ld_ok, rst_at, rst_len, busy_ack, stable, res, id, to, ok);
      checks++; if (port != p || id !== p[0] || !ld_ok || !ok || !stable) begin failures++; $display("FAIL rand%0d_seq got=port%0d ld%0d stable%0d exp=port%0d", k, port, ld_ok, stable, p); end
      checks++; if (res !== e || to !== 1'b0) begin failures++; $display("FAIL rand%0d_result got=q%h r%h dz%0d exp=q%h r%h dz%0d", k, res.q, res.r, res.dz, e.q, e.r, e.dz); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_both();
    test_dz();
    test_timeout();
    test_hold_rdy();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
